// File: rtl/sw_step_conditioner.sv
// ---------------------------------------------------------------------------
// sw_step_conditioner
//
// Cleans up the board slide switches before they reach the LFSR stage.
// Every switch is synchronised with two flops and then debounced.
// Clean one-clock strobes are produced from the debounced levels, so the LFSR
// can advance on clk with an enable instead of being clocked by a raw switch.
// The step switch also supports hold-to-auto-repeat.
//
// Ports
//   clk         in   1     system clock
//   rst         in   1     asynchronous reset, active-high
//   sw          in   N_SW  raw asynchronous switch inputs
//   sw_db       out  N_SW  debounced switch levels
//   sw_rise     out  N_SW  1-clk strobe, sw_db[i] went 0->1 this cycle
//   sw_fall     out  N_SW  1-clk strobe, sw_db[i] went 1->0 this cycle
//   step_pulse  out  1     1-clk step strobe (initial press plus auto-repeat)
//   step_load   out  1     step_pulse while sw_db[LOAD_IDX] is 1 (LFSR loads seed)
//   step_shift  out  1     step_pulse while sw_db[LOAD_IDX] is 0 (LFSR shifts once)
//
// All outputs are registered. There is no combinational path from sw to any
// output.
// ---------------------------------------------------------------------------
module sw_step_conditioner #(
  parameter int N_SW            = 10,
  parameter int STEP_IDX        = 8,
  parameter int LOAD_IDX        = 9,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter int REPEAT_EN       = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw,
  output logic [N_SW-1:0] sw_db,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            step_pulse,
  output logic            step_load,
  output logic            step_shift
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } state_t;

  logic [N_SW-1:0]  s1;
  logic [N_SW-1:0]  s2;
  logic [CNT_W-1:0] cnt     [N_SW];
  logic [CNT_W-1:0] cnt_nxt [N_SW];
  logic [N_SW-1:0]  db_nxt;
  logic [N_SW-1:0]  rise_nxt;
  logic [N_SW-1:0]  fall_nxt;

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nxt;
  logic             pulse_nxt;
  logic             step_rise_nxt;
  logic             step_lvl_nxt;

  // Two-flop synchroniser for every switch bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw;
      s2 <= s1;
    end
  end

  // Debounce logic for each bit.
  // A bit's counter runs only while the synchronised input disagrees with the
  // debounced level. Any agreement clears the counter, so a glitch restarts
  // the wait. On the final count the level flips, and the matching edge
  // strobe is produced in the same cycle. The counter is cleared at that
  // point, so it can never wrap.
  always_comb begin
    db_nxt   = sw_db;
    rise_nxt = '0;
    fall_nxt = '0;
    for (int i = 0; i < N_SW; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != sw_db[i]) begin
        if (cnt[i] == CNT_LAST) begin
          db_nxt[i]   = s2[i];
          rise_nxt[i] = s2[i];
          fall_nxt[i] = ~s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Registers for the debounce counters, the levels and the edge strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SW; i++) begin
        cnt[i] <= '0;
      end
      sw_db   <= '0;
      sw_rise <= '0;
      sw_fall <= '0;
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      sw_db   <= db_nxt;
      sw_rise <= rise_nxt;
      sw_fall <= fall_nxt;
    end
  end

  // The step FSM reads the next-cycle debounced values. Because of this, its
  // registered pulse lines up exactly with the registered sw_rise and sw_db.
  // This also means a release lands in the same cycle as a timer expiry it
  // collides with.
  assign step_rise_nxt = rise_nxt[STEP_IDX];
  assign step_lvl_nxt  = db_nxt[STEP_IDX];

  // Next-state logic for the step FSM.
  // Release is tested first, so it takes priority over a timer expiry.
  // When repeat is disabled, the timer holds at its final value in HOLD.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    pulse_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (step_rise_nxt) begin
          pulse_nxt = 1'b1;
          timer_nxt = '0;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!step_lvl_nxt) begin
          state_nxt = ST_IDLE;
        end else if (timer == HOLD_LAST) begin
          if (REPEAT_EN != 0) begin
            pulse_nxt = 1'b1;
            timer_nxt = '0;
            state_nxt = ST_REPEAT;
          end
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      ST_REPEAT: begin
        if (!step_lvl_nxt) begin
          state_nxt = ST_IDLE;
        end else if (timer == REPEAT_LAST) begin
          pulse_nxt = 1'b1;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // Registers for the FSM state, timer and step strobes.
  // Load and shift are split using the load switch level from the same
  // cycle the pulse appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      timer      <= '0;
      step_pulse <= 1'b0;
      step_load  <= 1'b0;
      step_shift <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      step_pulse <= pulse_nxt;
      step_load  <= pulse_nxt & db_nxt[LOAD_IDX];
      step_shift <= pulse_nxt & ~db_nxt[LOAD_IDX];
    end
  end

endmodule

// File: tb/tb_sw_step_conditioner.sv
// ---------------------------------------------------------------------------
// tb_sw_step_conditioner
//
// Testbench for two instances of sw_step_conditioner that share the same
// inputs. One instance has auto-repeat enabled and the other has it disabled.
// A reference model builds the expected outputs from a sliding window of
// sampled switch values and a schedule of step pulse times. Each expectation
// is queued when its stimulus is driven. A monitor compares the queued values
// just after every clock edge.
// ---------------------------------------------------------------------------
module tb_sw_step_conditioner;

  localparam int N_SW     = 10;
  localparam int STEP_IDX = 8;
  localparam int LOAD_IDX = 9;
  localparam int DB       = 4;
  localparam int HOLD     = 8;
  localparam int REP      = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_SW-1:0] sw;

  logic [N_SW-1:0] sw_db_r, sw_rise_r, sw_fall_r;
  logic            pulse_r, load_r, shift_r;
  logic [N_SW-1:0] sw_db_n, sw_rise_n, sw_fall_n;
  logic            pulse_n, load_n, shift_n;

  sw_step_conditioner #(
    .N_SW(N_SW), .STEP_IDX(STEP_IDX), .LOAD_IDX(LOAD_IDX),
    .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .REPEAT_EN(1)
  ) dut_rep (
    .clk(clk), .rst(rst), .sw(sw),
    .sw_db(sw_db_r), .sw_rise(sw_rise_r), .sw_fall(sw_fall_r),
    .step_pulse(pulse_r), .step_load(load_r), .step_shift(shift_r)
  );

  sw_step_conditioner #(
    .N_SW(N_SW), .STEP_IDX(STEP_IDX), .LOAD_IDX(LOAD_IDX),
    .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .REPEAT_EN(0)
  ) dut_norep (
    .clk(clk), .rst(rst), .sw(sw),
    .sw_db(sw_db_n), .sw_rise(sw_rise_n), .sw_fall(sw_fall_n),
    .step_pulse(pulse_n), .step_load(load_n), .step_shift(shift_n)
  );

  always #5 clk = ~clk;

  // Index 0 of pulse/load/shift is the repeat instance; index 1 is the
  // no-repeat instance.
  typedef struct {
    logic [N_SW-1:0] db;
    logic [N_SW-1:0] rise;
    logic [N_SW-1:0] fall;
    logic [1:0]      pulse;
    logic [1:0]      load;
    logic [1:0]      shift;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state.
  logic [N_SW-1:0] m_db;
  logic [N_SW-1:0] hist[$];
  int              cyc;
  bit              sched   [2];
  int              next_at [2];

  // Count one comparison, and report it if it does not match.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  task automatic modelReset();
    m_db = '0;
    hist.delete();
    repeat (DB + 1) hist.push_back('0);
    sched[0] = 1'b0;
    sched[1] = 1'b0;
  endtask

  // A debounced bit flips once the last DB synchronised samples all hold the
  // opposite level. Synchronisation delays each sample by two clocks.
  // A step pulse fires on the debounced rise and then at scheduled times
  // (rise+HOLD, then every REP). Any cycle where the step level is low
  // cancels the schedule.
  task automatic modelStep(input logic [N_SW-1:0] v, input logic r);
    exp_t            e;
    logic [N_SW-1:0] new_db;
    bit              flip;
    bit              p;
    cyc++;
    e.db = '0; e.rise = '0; e.fall = '0; e.pulse = '0; e.load = '0; e.shift = '0;
    if (r) begin
      modelReset();
      exp_q.push_back(e);
      return;
    end
    new_db = m_db;
    for (int i = 0; i < N_SW; i++) begin
      flip = 1'b1;
      for (int j = hist.size() - 1 - DB; j <= hist.size() - 2; j++)
        if (hist[j][i] == m_db[i]) flip = 1'b0;
      if (flip) new_db[i] = ~m_db[i];
    end
    e.db   = new_db;
    e.rise = new_db & ~m_db;
    e.fall = ~new_db & m_db;
    for (int d = 0; d < 2; d++) begin
      p = 1'b0;
      if (e.rise[STEP_IDX]) begin
        p = 1'b1;
        sched[d] = (d == 0);
        next_at[d] = cyc + HOLD;
      end else if (!new_db[STEP_IDX]) begin
        sched[d] = 1'b0;
      end else if (sched[d] && cyc == next_at[d]) begin
        p = 1'b1;
        next_at[d] = cyc + REP;
      end
      e.pulse[d] = p;
      e.load[d]  = p & new_db[LOAD_IDX];
      e.shift[d] = p & ~new_db[LOAD_IDX];
    end
    m_db = new_db;
    hist.push_back(v);
    if (hist.size() > DB + 1) void'(hist.pop_front());
    exp_q.push_back(e);
  endtask

  // Drive the inputs for the next clock edge and queue the expected outputs.
  task automatic applyStimulus(input logic [N_SW-1:0] v, input logic r);
    @(negedge clk);
    sw  = v;
    rst = r;
    modelStep(v, r);
  endtask

  task automatic driveFor(input logic [N_SW-1:0] v, input int n);
    repeat (n) applyStimulus(v, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " sw_db"},   32'(sw_db_r),   32'(sw_db_n) & 32'h0);
    checkOutput({tag, " sw_rise"}, 32'(sw_rise_r), 32'h0);
    checkOutput({tag, " sw_fall"}, 32'(sw_fall_r), 32'h0);
    checkOutput({tag, " steps"},   32'({pulse_r, load_r, shift_r}), 32'h0);
    checkOutput({tag, " sw_db_n"}, 32'(sw_db_n),   32'h0);
    checkOutput({tag, " steps_n"}, 32'({pulse_n, load_n, shift_n, sw_rise_n, sw_fall_n}), 32'h0);
  endtask

  // Assert reset between clock edges, then check that the outputs clear at once.
  task automatic asyncReset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkAllZero("async_reset");
  endtask

  // Monitor: compare the DUT outputs with the queued expectation after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("sw_db",        32'(sw_db_r),   32'(e.db));
        checkOutput("sw_rise",      32'(sw_rise_r), 32'(e.rise));
        checkOutput("sw_fall",      32'(sw_fall_r), 32'(e.fall));
        checkOutput("step_pulse",   32'(pulse_r),   32'(e.pulse[0]));
        checkOutput("step_load",    32'(load_r),    32'(e.load[0]));
        checkOutput("step_shift",   32'(shift_r),   32'(e.shift[0]));
        checkOutput("sw_db_n",      32'(sw_db_n),   32'(e.db));
        checkOutput("sw_rise_n",    32'(sw_rise_n), 32'(e.rise));
        checkOutput("sw_fall_n",    32'(sw_fall_n), 32'(e.fall));
        checkOutput("step_pulse_n", 32'(pulse_n),   32'(e.pulse[1]));
        checkOutput("step_load_n",  32'(load_n),    32'(e.load[1]));
        checkOutput("step_shift_n", 32'(shift_n),   32'(e.shift[1]));
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N_SW-1:0] v;
    int              n;
    rst = 1'b0;
    sw  = '0;
    cyc = 0;
    modelReset();

    // Reset asserted between clock edges while every switch is high.
    #2;
    rst = 1'b1;
    sw  = '1;
    #1;
    checkAllZero("power_on_reset");
    repeat (3) applyStimulus('1, 1'b1);

    // After release, all bits rise together at edge 6. Load is high, so step_load fires.
    driveFor('1, 8);
    driveFor('0, 10);

    // Glitch: three clocks high is too short. Then bounce and hold high.
    driveFor(10'h001, 3);
    driveFor(10'h000, 8);
    driveFor(10'h001, 1);
    driveFor(10'h000, 1);
    driveFor(10'h001, 10);
    driveFor(10'h000, 10);

    // Single shift step, pressed too briefly to reach HOLD.
    driveFor(10'h100, 5);
    driveFor(10'h000, 12);

    // Load step: the load switch is already debounced high.
    driveFor(10'h200, 8);
    driveFor(10'h300, 5);
    driveFor(10'h200, 12);
    driveFor(10'h000, 10);

    // Auto-repeat: held 30 clocks past the debounced rise.
    driveFor(10'h100, 30);
    driveFor(10'h000, 12);

    // Release in the same cycle as a REPEAT expiry (rise+14).
    driveFor(10'h100, 14);
    driveFor(10'h000, 12);

    // Release in the same cycle as the HOLD expiry (rise+8).
    driveFor(10'h100, 8);
    driveFor(10'h000, 12);

    // Reset during operation, then switches already high when reset is released.
    driveFor(10'h3FF, 10);
    asyncReset();
    repeat (3) applyStimulus(10'h3FF, 1'b1);
    driveFor(10'h3FF, 8);
    driveFor(10'h000, 10);

    // Random switch activity, with occasional long presses of the step switch.
    v = '0;
    for (int s = 0; s < 80; s++) begin
      v = v ^ N_SW'($urandom & $urandom);
      n = $urandom_range(1, 12);
      if ($urandom_range(0, 3) == 0) begin
        v[STEP_IDX] = 1'b1;
        n = $urandom_range(10, 30);
      end
      driveFor(v, n);
    end
    driveFor('0, 12);

    // Let the monitor use up the remaining expectations.
    repeat (3) @(posedge clk);
    #2;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
